led_shifter: RTL

Serial output stage for the front-panel display; sits directly downstream of the digit-multiplex sequencer. Every dwell period it snapshots the 72-bit, three-row digit word that the sequencer presents, shifts it MSB-first into the external chained shift/latch registers, and pulses the latch. It also owns the dwell timer whose one-cycle `timer_overflow` pulse advances the sequencer to the next digit.

---
 rtl/led_shifter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/led_shifter.sv
// -----------------------------------------------------------------------------
// led_shifter
//
// Serial output stage for the front-panel display. Once per dwell period it
// snapshots the WIDTH-bit digit word from the multiplex sequencer, shifts it
// MSB-first into the external chained shift/latch registers and pulses the
// latch strobe. It also owns the free-running dwell timer whose one-cycle
// overflow pulse advances the sequencer to the next digit.
//
// Parameters
//   WIDTH    bits per frame, {rowC,rowB,rowA}
//   CLK_DIV  clk cycles per sclk half-period (>= 1)
//   DWELL    clk cycles per digit period, >= 2*CLK_DIV*(WIDTH+1) + 8
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous, active-high reset
//   display_bits    in   frame from the sequencer, bit WIDTH-1 shifted first
//   timer_overflow  out  one-cycle pulse at the end of each dwell period
//   sclk            out  shift clock, external register samples on rising edge
//   sdata           out  serial data
//   sload           out  latch strobe, active-high, CLK_DIV cycles wide
//   sclr_n          out  external register clear, active-low
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module led_shifter #(
    parameter int WIDTH   = 72,
    parameter int CLK_DIV = 4,
    parameter int DWELL   = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] display_bits,
    output logic             timer_overflow,
    output logic             sclk,
    output logic             sdata,
    output logic             sload,
    output logic             sclr_n
);

    // ---------------------------------------------------------------------
    // Widths and typed compare constants
    // ---------------------------------------------------------------------
    localparam int CNT_W = $clog2(DWELL);
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DWELL - 2);
    // Capture two cycles after the wrap so the sequencer has settled its rows.
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(2);

    localparam logic [DIV_W-1:0] DIV_PHASE_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_CLEAR_END = DIV_W'(2 * CLK_DIV - 1);

    localparam logic [BIT_W-1:0] BITS_FULL = BIT_W'(WIDTH);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_tov;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bits;
    logic [WIDTH-1:0] r_shreg;
    logic             r_sclk;
    logic             r_sload;
    logic             r_sclr_n;

    // ---------------------------------------------------------------------
    // Dwell timer: free-runs 0..DWELL-1, independent of the FSM.
    // The overflow flop is set one cycle early so that it is high exactly
    // while the counter reads DWELL-1.
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, regardless of the order
    // in which always_ff blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_tov <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_tov <= (r_cnt == CNT_PRE);
        end
    end

    // ---------------------------------------------------------------------
    // Output sequencer
    //
    // r_div times both the sclk half-periods and the CLEAR/LOAD strobes.
    // The shift register's MSB drives sdata directly; after WIDTH left
    // shifts it is all zeros, so sdata is naturally low in LOAD and IDLE.
    // ---------------------------------------------------------------------
    // NOTE: every flop here is reset, including the shift register, so a
    // reset mid-frame leaves sdata low and no partial latch strobe escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_CLEAR;
            r_div    <= '0;
            r_bits   <= '0;
            r_shreg  <= '0;
            r_sclk   <= 1'b0;
            r_sload  <= 1'b0;
            r_sclr_n <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // Hold the external clear for 2*CLK_DIV cycles; sclr_n
                    // then stays high until the next reset.
                    if (r_div == DIV_CLEAR_END) begin
                        r_div    <= '0;
                        r_sclr_n <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                ST_IDLE: begin
                    // A capture point seen in any other state is dropped.
                    if (r_cnt == CNT_CAP) begin
                        r_shreg <= display_bits;
                        r_bits  <= BITS_FULL;
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (r_div == DIV_PHASE_END) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: present the next bit.
                            r_sclk  <= 1'b0;
                            r_shreg <= r_shreg << 1;
                            r_bits  <= r_bits - BIT_W'(1);
                            if (r_bits == BITS_LAST) begin
                                r_sload <= 1'b1;
                                r_state <= ST_LOAD;
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                ST_LOAD: begin
                    if (r_div == DIV_PHASE_END) begin
                        r_div   <= '0;
                        r_sload <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign timer_overflow = r_tov;
    assign sclk           = r_sclk;
    assign sdata          = r_shreg[WIDTH-1];
    assign sload          = r_sload;
    assign sclr_n         = r_sclr_n;

endmodule
